// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// csr_pkg : op encodings, CSR map, mstatus fields and FSM state for csr_ctrl
// Rev 1.0
// ============================================================================
package csr_pkg;

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;

  localparam logic [1:0] IDX_MEPC    = 2'd0;
  localparam logic [1:0] IDX_MCAUSE  = 2'd1;
  localparam logic [1:0] IDX_MSTATUS = 2'd2;
  localparam logic [1:0] IDX_MTVEC   = 2'd3;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;
  localparam int MST_W      = 13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } csr_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } csr_sel_t;

  function automatic csr_sel_t csr_decode(input logic [11:0] addr);
    csr_sel_t s;
    s.hit = 1'b1;
    s.idx = IDX_MEPC;
    case (addr)
      ADDR_MEPC:    s.idx = IDX_MEPC;
      ADDR_MCAUSE:  s.idx = IDX_MCAUSE;
      ADDR_MSTATUS: s.idx = IDX_MSTATUS;
      ADDR_MTVEC:   s.idx = IDX_MTVEC;
      default:      s.hit = 1'b0;
    endcase
    return s;
  endfunction

  // Interrupt-enable stacking on trap entry / return; only the low MST_W bits change.
  function automatic logic [MST_W-1:0] mstatus_trap(input logic [MST_W-1:0] m);
    logic [MST_W-1:0] r;
    r                         = m;
    r[MST_MPIE]               = m[MST_MIE];
    r[MST_MIE]                = 1'b0;
    r[MST_MPP_HI:MST_MPP_LO]  = 2'b11;
    return r;
  endfunction

  function automatic logic [MST_W-1:0] mstatus_mret(input logic [MST_W-1:0] m);
    logic [MST_W-1:0] r;
    r                         = m;
    r[MST_MIE]                = m[MST_MPIE];
    r[MST_MPIE]               = 1'b1;
    r[MST_MPP_HI:MST_MPP_LO]  = 2'b11;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_alu.sv
`default_nettype none
// ============================================================================
// csr_alu : read-modify-write value for CSRRW/CSRRS/CSRRC plus write suppress
// Rev 1.0
// ============================================================================
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  input  logic            i_src_x0,
  output logic [XLEN-1:0] o_new,
  output logic            o_suppress
);

  // Set/clear with an x0 source must not write, so side effects of the write are avoided.
  always_comb begin
    o_new      = '0;
    o_suppress = 1'b0;
    case (i_op)
      OP_CSRRW: o_new = i_src;
      OP_CSRRS: begin
        o_new      = i_old | i_src;
        o_suppress = i_src_x0;
      end
      OP_CSRRC: begin
        o_new      = i_old & ~i_src;
        o_suppress = i_src_x0;
      end
      default: o_new = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/csr_ctrl.sv
`default_nettype none
// ============================================================================
// csr_ctrl : multi-cycle CSR / ECALL / MRET sequencer in front of the CSR file
// Optional: CSR_CTRL_MSTATUS_STACK_EN adds mstatus stacking on ECALL/MRET
// Rev 1.0
// ============================================================================
module csr_ctrl
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = 32'h1800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_src_x0,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] mepc_rd,
  input  logic [XLEN-1:0] mcause_rd,
  input  logic [XLEN-1:0] mstatus_rd,
  input  logic [XLEN-1:0] mtvec_rd,
  output logic [XLEN-1:0] csrd,
  output logic [3:0]      csr_wen,
  output logic            ecall_flag,
  output logic [XLEN-1:0] trap_pc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  if (XLEN < MST_W || $bits(MSTATUS_RST) != XLEN) begin : g_param_check
    $error("csr_ctrl: XLEN must cover the mstatus MPP field");
  end

  csr_state_t      r_state;
  logic [2:0]      r_op;
  logic [11:0]     r_addr;
  logic [XLEN-1:0] r_src;
  logic            r_src_x0;
  logic [XLEN-1:0] r_pc;
  logic            r_req_ready;
  logic [3:0]      r_csr_wen;
  logic [XLEN-1:0] r_csrd;
  logic            r_ecall_flag;
  logic [XLEN-1:0] r_trap_pc;
  logic [XLEN-1:0] r_old;
  logic [XLEN-1:0] r_tgt;
  logic            r_illegal;
  logic            r_redir;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_illegal;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  csr_sel_t        w_sel;
  logic            w_is_csr;
  logic            w_illegal;
  logic            w_csr_ok;
  logic            w_suppress;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic [3:0]      w_wen;
  logic [XLEN-1:0] w_csrd;

  assign w_sel     = csr_decode(r_addr);
  assign w_is_csr  = (r_op <= OP_CSRRC);
  assign w_illegal = (r_op > OP_MRET) || (w_is_csr && !w_sel.hit);
  assign w_csr_ok  = w_is_csr && w_sel.hit;

  always_comb begin
    w_old = mepc_rd;
    case (w_sel.idx)
      IDX_MCAUSE:  w_old = mcause_rd;
      IDX_MSTATUS: w_old = mstatus_rd;
      IDX_MTVEC:   w_old = mtvec_rd;
      default:     w_old = mepc_rd;
    endcase
  end

  csr_alu #(.XLEN(XLEN)) u_alu (
    .i_op       (r_op),
    .i_old      (w_old),
    .i_src      (r_src),
    .i_src_x0   (r_src_x0),
    .o_new      (w_new),
    .o_suppress (w_suppress)
  );

  // Write strobe and data that the COMMIT cycle will present.
  always_comb begin
    w_wen  = '0;
    w_csrd = '0;
    if (w_csr_ok && !w_suppress) begin
      w_wen[w_sel.idx] = 1'b1;
      w_csrd           = w_new;
    end
`ifdef CSR_CTRL_MSTATUS_STACK_EN
    else if (r_op == OP_ECALL) begin
      w_wen[IDX_MSTATUS] = 1'b1;
      w_csrd             = {mstatus_rd[XLEN-1:MST_W], mstatus_trap(mstatus_rd[MST_W-1:0])};
    end else if (r_op == OP_MRET) begin
      w_wen[IDX_MSTATUS] = 1'b1;
      w_csrd             = {mstatus_rd[XLEN-1:MST_W], mstatus_mret(mstatus_rd[MST_W-1:0])};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_op             <= '0;
      r_addr           <= '0;
      r_src            <= '0;
      r_src_x0         <= 1'b0;
      r_pc             <= '0;
      r_req_ready      <= 1'b1;
      r_csr_wen        <= '0;
      r_csrd           <= '0;
      r_ecall_flag     <= 1'b0;
      r_trap_pc        <= '0;
      r_old            <= '0;
      r_tgt            <= '0;
      r_illegal        <= 1'b0;
      r_redir          <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_rsp_rdata      <= '0;
      r_rsp_illegal    <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_op        <= req_op;
            r_addr      <= req_addr;
            r_src       <= req_src;
            r_src_x0    <= req_src_x0;
            r_pc        <= req_pc;
            r_req_ready <= 1'b0;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_old        <= w_csr_ok ? w_old : '0;
          r_illegal    <= w_illegal;
          r_redir      <= (r_op == OP_ECALL) || (r_op == OP_MRET);
          r_tgt        <= (r_op == OP_ECALL) ? mtvec_rd :
                          (r_op == OP_MRET)  ? mepc_rd  : '0;
          r_csr_wen    <= w_wen;
          r_csrd       <= w_csrd;
          r_ecall_flag <= (r_op == OP_ECALL);
          r_trap_pc    <= (r_op == OP_ECALL) ? r_pc : '0;
          r_state      <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_csr_wen        <= '0;
          r_csrd           <= '0;
          r_ecall_flag     <= 1'b0;
          r_trap_pc        <= '0;
          r_rsp_valid      <= 1'b1;
          r_rsp_rdata      <= r_old;
          r_rsp_illegal    <= r_illegal;
          r_redirect_valid <= r_redir;
          r_redirect_pc    <= r_tgt;
          r_state          <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_rsp_illegal    <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_req_ready      <= 1'b1;
            r_state          <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are masked by rst so a reset landing on COMMIT never writes the CSR file.
  assign csr_wen        = rst ? '0 : r_csr_wen;
  assign csrd           = rst ? '0 : r_csrd;
  assign ecall_flag     = rst ? 1'b0 : r_ecall_flag;
  assign trap_pc        = rst ? '0 : r_trap_pc;
  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_illegal    = r_rsp_illegal;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_csr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_csr_ctrl : directed + random transactions against a behavioural CSR model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_csr_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_src_x0;
  logic [2:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_src, req_pc;
  logic [XLEN-1:0] mepc_rd, mcause_rd, mstatus_rd, mtvec_rd;
  logic [XLEN-1:0] csrd, trap_pc, rsp_rdata, redirect_pc;
  logic [3:0]      csr_wen;
  logic            ecall_flag, rsp_valid, rsp_ready, rsp_illegal, redirect_valid;

  logic [31:0] csrv [4];
  assign mepc_rd    = csrv[0];
  assign mcause_rd  = csrv[1];
  assign mstatus_rd = csrv[2];
  assign mtvec_rd   = csrv[3];

  always #5 clk = ~clk;

  csr_ctrl #(.XLEN(XLEN), .MSTATUS_RST(32'h1800)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_src_x0(req_src_x0), .req_pc(req_pc),
    .mepc_rd(mepc_rd), .mcause_rd(mcause_rd), .mstatus_rd(mstatus_rd), .mtvec_rd(mtvec_rd),
    .csrd(csrd), .csr_wen(csr_wen), .ecall_flag(ecall_flag), .trap_pc(trap_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_illegal(rsp_illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] csrd;
    logic        ecall;
    logic [31:0] tpc;
    logic [31:0] rdata;
    logic        ill;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  // Expected outcome of one request, from the architectural CSR rules.
  function automatic exp_t model(input logic [2:0] op, input logic [11:0] addr,
                                 input logic [31:0] src, input logic x0, input logic [31:0] pc);
    exp_t e;
    int which;
    logic [31:0] old, nv, m;
    e = '0;
    case (addr)
      12'h341: which = 0;
      12'h342: which = 1;
      12'h300: which = 2;
      12'h305: which = 3;
      default: which = -1;
    endcase
    if (op > 3'd4 || (op <= 3'd2 && which < 0)) begin
      e.ill = 1'b1;
      return e;
    end
    if (op <= 3'd2) begin
      old     = csrv[which];
      e.rdata = old;
      nv = (op == 3'd0) ? src : (op == 3'd1) ? (old | src) : (old & ~src);
      if (op == 3'd0 || !x0) begin
        e.wen  = 4'(1 << which);
        e.csrd = nv;
      end
    end else if (op == 3'd3) begin
      e.ecall = 1'b1;
      e.tpc   = pc;
      e.rv    = 1'b1;
      e.rpc   = csrv[3];
`ifdef CSR_CTRL_MSTATUS_STACK_EN
      m      = csrv[2];
      e.wen  = 4'b0100;
      e.csrd = (m & ~32'h1888) | (((m >> 3) & 32'h1) << 7) | 32'h1800;
`endif
    end else begin
      e.rv  = 1'b1;
      e.rpc = csrv[0];
`ifdef CSR_CTRL_MSTATUS_STACK_EN
      m      = csrv[2];
      e.wen  = 4'b0100;
      e.csrd = (m & ~32'h1888) | (((m >> 7) & 32'h1) << 3) | 32'h0080 | 32'h1800;
`endif
    end
    m = '0;
    return e;
  endfunction

  task automatic run_txn(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic x0, input logic [31:0] pc, input int hold, input string nm);
    exp_t e;
    e = model(op, addr, src, x0, pc);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src; req_src_x0 = x0; req_pc = pc;
    chk({nm, "/idle_ready"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_addr = 12'($urandom); req_src = $urandom;
    req_pc = $urandom; req_src_x0 = 1'($urandom);
    @(negedge clk);
    chk({nm, "/exec_wen"}, csr_wen, 0);
    chk({nm, "/exec_ready"}, req_ready, 0);
    chk({nm, "/exec_rspv"}, rsp_valid, 0);
    @(negedge clk);
    chk({nm, "/wen"}, csr_wen, e.wen);
    chk({nm, "/csrd"}, csrd, e.csrd);
    chk({nm, "/ecall"}, ecall_flag, e.ecall);
    chk({nm, "/trap_pc"}, trap_pc, e.tpc);
    chk({nm, "/commit_rspv"}, rsp_valid, 0);
    for (int i = 0; i < 4; i++) csrv[i] = $urandom;
    @(negedge clk);
    chk({nm, "/rspv"}, rsp_valid, 1);
    chk({nm, "/rdata"}, rsp_rdata, e.rdata);
    chk({nm, "/illegal"}, rsp_illegal, e.ill);
    chk({nm, "/redir_v"}, redirect_valid, e.rv);
    chk({nm, "/redir_pc"}, redirect_pc, e.rpc);
    chk({nm, "/resp_wen"}, csr_wen, 0);
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1; req_op = 3'd0; req_addr = 12'h305; req_src = $urandom; req_src_x0 = 1'b0;
      @(negedge clk);
      chk({nm, "/hold_rspv"}, rsp_valid, 1);
      chk({nm, "/hold_rdata"}, rsp_rdata, e.rdata);
      chk({nm, "/hold_ill"}, rsp_illegal, e.ill);
      chk({nm, "/hold_rpc"}, redirect_pc, e.rpc);
      chk({nm, "/hold_ready"}, req_ready, 0);
      chk({nm, "/hold_wen"}, csr_wen, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "/done_rspv"}, rsp_valid, 0);
    chk({nm, "/done_ready"}, req_ready, 1);
    chk({nm, "/done_redir"}, redirect_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        x0;
    int          r;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0;
    req_src_x0 = 1'b0; req_pc = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) csrv[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/req_ready", req_ready, 1);
    chk("rst/rsp_valid", rsp_valid, 0);
    chk("rst/csr_wen", csr_wen, 0);
    chk("rst/ecall", ecall_flag, 0);
    chk("rst/csrd", csrd, 0);
    chk("rst/redir_v", redirect_valid, 0);
    chk("rst/illegal", rsp_illegal, 0);

    csrv[0] = 0; csrv[1] = 0; csrv[2] = 32'h1800; csrv[3] = 0;
    run_txn(3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 0, "csrrw_mtvec");
    csrv[0] = 0; csrv[1] = 0; csrv[2] = 32'h1800; csrv[3] = 0;
    run_txn(3'd1, 12'h300, 32'h8, 1'b0, 32'h0, 0, "csrrs_mstatus");
    csrv[0] = 0; csrv[1] = 0; csrv[2] = 32'h1800; csrv[3] = 0;
    run_txn(3'd1, 12'h300, 32'h0, 1'b1, 32'h0, 0, "csrrs_x0");
    csrv[0] = 0; csrv[1] = 0; csrv[2] = 32'h1808; csrv[3] = 32'h8000_0100;
    run_txn(3'd3, 12'h000, 32'h0, 1'b0, 32'h8000_0040, 0, "ecall");
    csrv[0] = 32'h8000_0044; csrv[1] = 0; csrv[2] = 32'h1880; csrv[3] = 32'h8000_0100;
    run_txn(3'd4, 12'h302, 32'h0, 1'b0, 32'h0, 0, "mret");
    csrv[0] = 1; csrv[1] = 2; csrv[2] = 3; csrv[3] = 4;
    run_txn(3'd0, 12'h7C0, 32'hDEAD_BEEF, 1'b0, 32'h0, 5, "illegal_addr_hold");
    run_txn(3'd2, 12'h342, 32'h0000_00F0, 1'b0, 32'h0, 0, "csrrc_mcause");
    for (int o = 5; o < 8; o++) run_txn(3'(o), 12'h341, 32'h1, 1'b0, 32'h0, 0, "illegal_op");

    // Reset landing in the COMMIT cycle of a CSRRW.
    csrv[0] = 0; csrv[1] = 0; csrv[2] = 32'h1800; csrv[3] = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 12'h305; req_src = 32'h1234_5678; req_src_x0 = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstc/wen_masked", csr_wen, 0);
    chk("rstc/csrd_masked", csrd, 0);
    chk("rstc/ecall_masked", ecall_flag, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstc/req_ready", req_ready, 1);
    chk("rstc/rsp_valid", rsp_valid, 0);
    chk("rstc/csr_wen", csr_wen, 0);
    chk("rstc/rdata", rsp_rdata, 0);
    chk("rstc/redir_v", redirect_valid, 0);
    @(negedge clk);
    chk("rstc/no_resume", rsp_valid, 0);
    run_txn(3'd1, 12'h341, 32'h0F0F_0000, 1'b0, 32'h0, 0, "post_rst");

    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < 4; i++) csrv[i] = $urandom;
      r = $urandom_range(0, 9);
      if (r <= 5)      op = 3'(r % 3);
      else if (r == 6) op = 3'd3;
      else if (r == 7) op = 3'd4;
      else             op = 3'($urandom_range(5, 7));
      case ($urandom_range(0, 4))
        0: addr = 12'h341;
        1: addr = 12'h342;
        2: addr = 12'h300;
        3: addr = 12'h305;
        default: addr = 12'($urandom);
      endcase
      x0  = ($urandom_range(0, 3) == 0);
      src = x0 ? 32'h0 : $urandom;
      run_txn(op, addr, src, x0, $urandom, $urandom_range(0, 2), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
